// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared state encoding and cycle limits for the SPI chip-select arbiter
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        WAIT_RDY,
        WAIT_BUSY,
        WAIT_DONE,
        CS_HOLD,
        GAP
    } arb_state_t;

    localparam int MIN_NUM_REQ         = 2;
    localparam int MAX_NUM_REQ         = 8;
    localparam int MIN_CS_SETUP_CICLOS = 1;
    localparam int MIN_CS_HOLD_CICLOS  = 1;
    localparam int MIN_GAP_CICLOS      = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_arb_rr.sv
// rtl/spi_arb_rr.sv - combinational winner select; SPI_ARB_PRIORIDADE_FIXA_EN selects fixed priority
module spi_arb_rr #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic               valid_o
);

    logic [PTR_W-1:0] ptr_eff;

`ifdef SPI_ARB_PRIORIDADE_FIXA_EN
    // Search always starts at requester 0, so the lowest set index wins.
    assign ptr_eff = '0;
`else
    assign ptr_eff = ptr_i;
`endif

    // Walk from the farthest offset to the nearest so the first set bit after ptr_eff wins.
    always_comb begin
        int idx;
        winner_o = '0;
        idx      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_eff) + k) % NUM_REQ;
            if (req_i[idx]) begin
                winner_o = NUM_REQ'(1) << idx;
            end
        end
        valid_o = |req_i;
    end

endmodule

// File: rtl/spi_arbitro_cs.sv
// rtl/spi_arbitro_cs.sv - shares one spi_master between NUM_REQ requesters with per-requester chip select
// Build option: SPI_ARB_PRIORIDADE_FIXA_EN selects fixed priority instead of round-robin.
module spi_arbitro_cs
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int LEN_W           = 4,
    parameter int CS_SETUP_CICLOS = 2,
    parameter int CS_HOLD_CICLOS  = 2,
    parameter int GAP_CICLOS      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ*8-1:0]     req_tx_dado,
    output logic [NUM_REQ-1:0]       byte_ack,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic [7:0]               rx_dado_out,
    output logic [NUM_REQ-1:0]       rx_valido_out,
    output logic [NUM_REQ-1:0]       cs_n,
    output logic [7:0]               m_tx_dado,
    output logic                     m_tx_valido,
    input  logic                     m_tx_pronto,
    input  logic [7:0]               m_rx_dado,
    input  logic                     m_rx_valido
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int TMR_MAX = max3(CS_SETUP_CICLOS, CS_HOLD_CICLOS, GAP_CICLOS);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] cs_n_q, cs_n_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] rxv_q, rxv_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               txv_q, txv_d;
    logic [7:0]         txd_q, txd_d;
    logic [7:0]         rxd_q, rxd_d;

    logic [NUM_REQ-1:0] win;
    logic               win_valid;
    logic [LEN_W-1:0]   win_len;
    logic [7:0]         own_tx;
    logic [PTR_W-1:0]   own_idx;
    logic [PTR_W-1:0]   ptr_next;

    spi_arb_rr #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (win),
        .valid_o  (win_valid)
    );

    // One-hot muxes: winner's length at grant time, owner's byte and index during the transaction.
    always_comb begin
        win_len = '0;
        own_tx  = '0;
        own_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                win_len = win_len | req_len[i*LEN_W +: LEN_W];
            end
            if (gnt_q[i]) begin
                own_tx  = own_tx | req_tx_dado[i*8 +: 8];
                own_idx = PTR_W'(i);
            end
        end
        ptr_next = (own_idx == PTR_W'(NUM_REQ - 1)) ? '0 : own_idx + PTR_W'(1);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cs_n_d  = cs_n_q;
        len_d   = len_q;
        tmr_d   = tmr_q;
        ptr_d   = ptr_q;
        txd_d   = txd_q;
        rxd_d   = rxd_q;
        done_d  = '0;
        ack_d   = '0;
        rxv_d   = '0;
        txv_d   = 1'b0;

        if (m_rx_valido && (gnt_q != '0)) begin
            rxd_d = m_rx_dado;
            rxv_d = gnt_q;
        end

        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = CS_SETUP;
                    gnt_d   = win;
                    cs_n_d  = ~win;
                    len_d   = win_len;
                    tmr_d   = TMR_W'(CS_SETUP_CICLOS - 1);
                end
            end
            CS_SETUP: begin
                if (tmr_q == '0) state_d = WAIT_RDY;
                else             tmr_d   = tmr_q - TMR_W'(1);
            end
            WAIT_RDY: begin
                if (m_tx_pronto) begin
                    txv_d   = 1'b1;
                    txd_d   = own_tx;
                    ack_d   = gnt_q;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // pronto is still high on the cycle after the start pulse; wait for it to drop.
                if (!m_tx_pronto) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (m_tx_pronto) begin
                    if (len_q == '0) begin
                        state_d = CS_HOLD;
                        tmr_d   = TMR_W'(CS_HOLD_CICLOS - 1);
                    end else begin
                        len_d   = len_q - LEN_W'(1);
                        state_d = WAIT_RDY;
                    end
                end
            end
            CS_HOLD: begin
                if (tmr_q == '0) begin
                    state_d = GAP;
                    tmr_d   = TMR_W'(GAP_CICLOS - 1);
                    cs_n_d  = '1;
                    done_d  = gnt_q;
                    gnt_d   = '0;
`ifdef SPI_ARB_PRIORIDADE_FIXA_EN
                    ptr_d   = '0;
`else
                    ptr_d   = ptr_next;
`endif
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            GAP: begin
                if (tmr_q == '0) state_d = IDLE;
                else             tmr_d   = tmr_q - TMR_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cs_n_q  <= '1;
            done_q  <= '0;
            ack_q   <= '0;
            rxv_q   <= '0;
            len_q   <= '0;
            tmr_q   <= '0;
            ptr_q   <= '0;
            txv_q   <= 1'b0;
            txd_q   <= '0;
            rxd_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            rxv_q   <= rxv_d;
            len_q   <= len_d;
            tmr_q   <= tmr_d;
            ptr_q   <= ptr_d;
            txv_q   <= txv_d;
            txd_q   <= txd_d;
            rxd_q   <= rxd_d;
        end
    end

    assign gnt           = gnt_q;
    assign cs_n          = cs_n_q;
    assign done          = done_q;
    assign byte_ack      = ack_q;
    assign rx_valido_out = rxv_q;
    assign rx_dado_out   = rxd_q;
    assign m_tx_valido   = txv_q;
    assign m_tx_dado     = txd_q;

endmodule

// File: tb/tb_spi_arbitro_cs.sv
// tb/tb_spi_arbitro_cs.sv - directed self-checking bench for spi_arbitro_cs with a simple spi_master model
module tb_spi_arbitro_cs;

    localparam int NUM_REQ  = 2;
    localparam int LEN_W    = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int GAP      = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [7:0]  req_len = '0;
    wire  [15:0] req_tx_dado;
    logic [1:0]  byte_ack, gnt, done, rx_valido_out, cs_n;
    logic [7:0]  rx_dado_out, m_tx_dado;
    logic        m_tx_valido;
    logic        m_tx_pronto;
    logic [7:0]  m_rx_dado = '0;
    logic        m_rx_valido = 1'b0;

    always #5 clk = ~clk;

    spi_arbitro_cs #(
        .NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .CS_SETUP_CICLOS(CS_SETUP),
        .CS_HOLD_CICLOS(CS_HOLD), .GAP_CICLOS(GAP)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_tx_dado(req_tx_dado),
        .byte_ack(byte_ack), .gnt(gnt), .done(done), .rx_dado_out(rx_dado_out),
        .rx_valido_out(rx_valido_out), .cs_n(cs_n), .m_tx_dado(m_tx_dado),
        .m_tx_valido(m_tx_valido), .m_tx_pronto(m_tx_pronto), .m_rx_dado(m_rx_dado),
        .m_rx_valido(m_rx_valido)
    );

    // spi_master stand-in: pronto drops the cycle after the start pulse, stays low busy_len cycles.
    int busy_len = 40;
    int busy_cnt;
    always @(posedge clk) begin
        if (rst) begin
            m_tx_pronto <= 1'b0;
            busy_cnt    <= 3;
        end else if (m_tx_valido) begin
            m_tx_pronto <= 1'b0;
            busy_cnt    <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt    <= busy_cnt - 1;
            m_tx_pronto <= (busy_cnt == 1);
        end
    end

    // Requesters: each advances to its next table byte on the edge after byte_ack.
    logic [7:0] tab0 [0:3];
    logic [7:0] tab1 [0:3];
    int         idx0, idx1;
    assign req_tx_dado = {tab1[idx1[1:0]], tab0[idx0[1:0]]};
    always @(posedge clk) begin
        if (rst) begin
            idx0 <= 0;
            idx1 <= 0;
        end else begin
            if (byte_ack[0]) idx0 <= idx0 + 1;
            if (byte_ack[1]) idx1 <= idx1 + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] tx_q[$];
    logic [1:0] ack_q[$];
    logic [1:0] done_q[$];
    logic [1:0] gnt_q[$];
    int         cyc = 0, valid_cyc = 0, done_cyc = 0, cs_fall_cyc = 0, pr_rise_cyc = 0;
    int         twohot = 0, cs_mismatch = 0, gap_run = 0, min_gap = 1000;
    logic [1:0] prev_cs = 2'b11, prev_gnt = 2'b00;
    logic       prev_pr = 1'b0;

    task automatic clear_obs();
        tx_q.delete(); ack_q.delete(); done_q.delete(); gnt_q.delete();
        twohot = 0; cs_mismatch = 0; min_gap = 1000;
    endtask

    // Advance one cycle and record everything visible at the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (m_tx_valido) begin tx_q.push_back(m_tx_dado); valid_cyc = cyc; end
        if (byte_ack != 2'b00) ack_q.push_back(byte_ack);
        if (done != 2'b00) begin done_q.push_back(done); done_cyc = cyc; end
        if (gnt != 2'b00 && prev_gnt == 2'b00) gnt_q.push_back(gnt);
        if ((gnt & (gnt - 2'd1)) != 2'b00) twohot++;
        if (cs_n !== ~gnt) cs_mismatch++;
        if (&prev_cs && !(&cs_n)) begin
            cs_fall_cyc = cyc;
            if (gap_run < min_gap) min_gap = gap_run;
        end
        gap_run  = (&cs_n) ? gap_run + 1 : 0;
        if (m_tx_pronto && !prev_pr) pr_rise_cyc = cyc;
        prev_cs  = cs_n;
        prev_gnt = gnt;
        prev_pr  = m_tx_pronto;
    endtask

    task automatic wait_done(input int n, input int lim, input string tag);
        int cnt = 0;
        int t = 0;
        while (cnt < n && t < lim) begin
            tick();
            if (done != 2'b00) cnt++;
            t++;
        end
        check(tag, cnt, n);
    endtask

    task automatic wait_gnt(input logic [1:0] g, input int lim, input string tag);
        int t = 0;
        while (gnt !== g && t < lim) begin tick(); t++; end
        check(tag, gnt, g);
    endtask

    logic [1:0] exp_g  [0:3];
    logic [7:0] exp_tx [0:3];
    int         t;

    initial begin
        tab0 = '{8'hA5, 8'h00, 8'h00, 8'h00};
        tab1 = '{8'h00, 8'h00, 8'h00, 8'h00};
        repeat (2) tick();
        check("rst_cs_n", cs_n, 2'b11);
        check("rst_gnt", gnt, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_txv", m_tx_valido, 1'b0);
        check("rst_txd", m_tx_dado, 8'h00);
        check("rst_rxv", rx_valido_out, 2'b00);
        rst = 1'b0;
        repeat (6) tick();

        // Single byte, long busy.
        clear_obs();
        req = 2'b01;
        wait_done(1, 300, "t1_done_seen");
        req = 2'b00;
        tick();
        check("t1_ntx", tx_q.size(), 1);
        check("t1_byte", tx_q[0], 8'hA5);
        check("t1_nack", ack_q.size(), 1);
        check("t1_ack", ack_q[0], 2'b01);
        // CS_SETUP cycles, then one WAIT_RDY cycle before the registered pulse.
        check("t1_setup", valid_cyc - cs_fall_cyc, CS_SETUP + 1);
        // pronto sampled at the closing edge, then CS_HOLD cycles, then done visible.
        check("t1_hold", done_cyc - pr_rise_cyc, CS_HOLD + 1);
        check("t1_done_owner", done_q[0], 2'b01);
        check("t1_cs_idle", cs_n, 2'b11);

        // Four bytes.
        busy_len = 5;
        clear_obs();
        tab0 = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (5) tick();
        req_len = 8'h03;
        req = 2'b01;
        wait_done(1, 400, "t2_done_seen");
        req = 2'b00;
        repeat (4) tick();
        check("t2_ntx", tx_q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t2_byte%0d", i), tx_q[i], tab0[i]);
        check("t2_nack", ack_q.size(), 4);
        check("t2_cs_follows_gnt", cs_mismatch, 0);
        check("t2_ndone", done_q.size(), 1);

        // Both requesting from reset.
        rst = 1'b1; tick(); rst = 1'b0;
        clear_obs();
        tab0 = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        tab1 = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
        req_len = 8'h00;
        repeat (5) tick();
`ifdef SPI_ARB_PRIORIDADE_FIXA_EN
        exp_g  = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_tx = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
`else
        exp_g  = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_tx = '{8'hC0, 8'hD0, 8'hC1, 8'hD1};
`endif
        req = 2'b11;
        wait_done(4, 600, "t3_done_seen");
        req = 2'b00;
        tick();
        check("t3_ngnt", gnt_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_gnt%0d", i), gnt_q[i], exp_g[i]);
            check($sformatf("t3_tx%0d", i), tx_q[i], exp_tx[i]);
        end
        check("t3_twohot", twohot, 0);
        check("t3_gap_min", min_gap >= GAP, 1'b1);

        // RX routing and reset in WAIT_DONE of requester 1.
        busy_len = 40;
        clear_obs();
        tab1 = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
        repeat (3) tick();
        req = 2'b10;
        wait_gnt(2'b10, 50, "t4_gnt1");
        m_rx_dado = 8'h5A;
        m_rx_valido = 1'b1;
        tick();
        m_rx_valido = 1'b0;
        check("t4_rx_dado", rx_dado_out, 8'h5A);
        check("t4_rx_valido", rx_valido_out, 2'b10);
        tick();
        check("t4_rx_one_pulse", rx_valido_out, 2'b00);
        t = 0;
        while (tx_q.size() == 0 && t < 50) begin tick(); t++; end
        check("t4_tx_seen", tx_q.size(), 1);
        repeat (5) tick();
        check("t4_busy_gnt", gnt, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_rst_cs_n", cs_n, 2'b11);
        check("t4_rst_gnt", gnt, 2'b00);
        check("t4_rst_done", done, 2'b00);
        clear_obs();
        wait_done(1, 300, "t4_restart_done");
        req = 2'b00;
        tick();
        check("t4_restart_gnt", gnt_q.size() > 0 ? gnt_q[0] : 2'b00, 2'b10);
        check("t4_restart_setup", valid_cyc - cs_fall_cyc, CS_SETUP + 1);
        check("t4_restart_byte", tx_q.size() > 0 ? tx_q[0] : 8'h00, 8'hE1);
        check("t4_ndone", done_q.size(), 1);
        check("t4_done_owner", done_q.size() > 0 ? done_q[0] : 2'b00, 2'b10);

        // RX while idle is ignored.
        repeat (3) tick();
        m_rx_dado = 8'h77;
        m_rx_valido = 1'b1;
        tick();
        m_rx_valido = 1'b0;
        check("t5_idle_rx_valido", rx_valido_out, 2'b00);
        tick();
        check("t5_idle_rx_dado", rx_dado_out, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
